fc_layer_simd: RTL and testbench
================================

Name: fc_layer_simd

Overview:
Parametrised successor to the single-lane fully-connected layer: a LANES-wide SIMD FC layer with zero-skipping of input activations, per-neuron bias, arithmetic output scaling, saturation and optional ReLU. It accepts one input vector through a valid/ready handshake and holds weights and biases in an internal register file written through a side port. It emits one saturated DATA_W result per cycle, in ascending neuron order. It sits between activation producers and the next layer of the neural engine.

Parameters:
DATA_W, 8, width of signed inputs, weights, biases and outputs
NUM_NEURONS, 10, number of output neurons (≥1)
NUM_INPUTS, 4, input vector length (≥1)
LANES, 2, neurons computed in parallel per MAC cycle (≥1)
ACC_W, 24, signed accumulator width
FRAC_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin one inference; sampled only in IDLE
relu_en  in  1  ReLU mode; latched on accepted start
in_valid  in  1  input element valid
in_data  in  DATA_W  signed input element
in_ready  out  1  block accepts an input element
w_we  in  1  weight/bias write strobe
w_addr  in  clog2(NUM_NEURONS*(NUM_INPUTS+1))  word address = n*(NUM_INPUTS+1)+i; i==NUM_INPUTS selects the bias
w_data  in  DATA_W  signed weight/bias value
out_valid  out  1  data_out/out_idx valid this cycle
data_out  out  DATA_W  signed neuron result
out_idx  out  clog2(NUM_NEURONS)  neuron index of data_out
done  out  1  one-cycle pulse after the last output
busy  out  1  high whenever the state is not IDLE
nnz_count  out  clog2(NUM_INPUTS+1)  count of nonzero inputs in the current vector

Behaviour:
- Reset (asynchronous): state IDLE. in_ready, out_valid, done and busy are 0. data_out, out_idx and nnz_count are 0. Weight/bias storage is not reset.
- Weight writes take effect at the clock edge, only in IDLE. w_we outside IDLE is ignored, as is an address ≥ NUM_NEURONS*(NUM_INPUTS+1).
- States: IDLE, LOAD, BIAS, MAC, EMIT, DONE.
- IDLE: start=1 → LOAD; latch relu_en; clear the input buffer, nonzero mask and nnz_count. start in any other state is ignored.
- LOAD: in_ready=1. Each cycle with in_valid & in_ready:
  - store the element at the next index 0..NUM_INPUTS-1;
  - set its mask bit if nonzero and increment nnz_count.
  - After element NUM_INPUTS-1 → BIAS with group g=0.
- BIAS (1 cycle): each lane k loads acc[k] = sign-extended bias of neuron g*LANES+k.
  - Next state is MAC if any mask bit is set, else EMIT.
  - Working mask = copy of the input mask.
- MAC: each cycle, a priority encoder selects the lowest set bit j of the working mask.
  - Every lane does acc[k] += x[j]*w[n_k][j] as a full-precision product, sign-extended to ACC_W with wraparound.
  - Bit j is cleared. After the last set bit is consumed → EMIT.
  - A group therefore takes exactly nnz_count MAC cycles; zero inputs cost no cycles.
- EMIT: one lane per cycle, lane 0 first, for lanes whose neuron index is < NUM_NEURONS (a partial last group emits fewer). Per emitted lane:
  - out_valid=1, out_idx=n;
  - data_out = sat(acc>>>FRAC_SHIFT) to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
  - if relu_en was latched, negative results become 0.
- After the last valid lane of a group: go to BIAS for g+1 if more neurons remain, else DONE.
- DONE: done=1 for one cycle, then IDLE. The cycle after DONE, start is accepted again.
- Cycle count, start edge to done (in_valid held high): 1 + NUM_INPUTS + Σ_groups(1 + nnz_count + lanes_in_group) + 1.
- in_valid outside LOAD is ignored. data_out and out_idx hold their last value when out_valid=0.

Test Plan:
1. Dense: all weights 1, biases 0, inputs 1,2,3,4, relu_en=0 → ten outputs of 10 with out_idx 0..9, nnz_count=4, done at cycle 1+4+5·(1+4+2)+1=41 after start.
2. Sparse: inputs 0,5,0,0, weights w[n][1]=n, biases 0 → outputs 5n, nnz_count=1, exactly 1 MAC cycle per group, done at cycle 26.
3. All-zero inputs, bias[n]=n-3 → outputs n-3, no MAC cycles; rerun with relu_en=1 → neurons 0..2 output 0.
4. Saturation: weights 127, inputs 127, bias 127 → all outputs 127; weights -128, inputs 127 → -128 (relu_en=0) and 0 (relu_en=1).
5. NUM_NEURONS=5, LANES=2 → exactly 5 out_valid pulses, last group emits only out_idx 4; LANES=1 gives identical values to test 1.
6. Robustness:
   - assert rst_n=0 mid-MAC → outputs 0 immediately, IDLE after release, weights retained, next run correct;
   - start and w_we pulsed while busy → ignored, results unchanged.

Source files
------------

// File: rtl/fc_layer_simd.sv
// LANES-wide fully-connected layer: buffers one input vector, skips zero activations,
// then adds bias, scales, saturates and optionally applies ReLU to each neuron result.
module fc_layer_simd #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned LANES       = 2,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned FRAC_SHIFT  = 0,
  localparam int unsigned DEPTH = NUM_NEURONS * (NUM_INPUTS + 1),
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int unsigned NNZ_W = $clog2(NUM_INPUTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]  out_idx,
  output logic              done,
  output logic              busy,
  output logic [NNZ_W-1:0]  nnz_count
);

  localparam int unsigned NUM_GROUPS = (NUM_NEURONS + LANES - 1) / LANES;
  localparam int unsigned GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned XW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIAS, S_MAC, S_EMIT, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] wmem [DEPTH];
  logic signed [DATA_W-1:0] x_q [NUM_INPUTS];
  logic signed [DATA_W-1:0] x_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]    mask_q, mask_d, wmask_q, wmask_d, wmask_clr;
  logic [XW-1:0]            idx_q, idx_d, sel;
  logic [NNZ_W-1:0]         nnz_q, nnz_d;
  logic [GW-1:0]            grp_q, grp_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic signed [PW-1:0]     prod [LANES];
  logic                     relu_q, relu_d;
  logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                     done_q, done_d, busy_q, busy_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic                     load_last, lane_last, grp_last;
  int unsigned              nbase;

  function automatic logic [AW-1:0] waddr(input int unsigned n, input int unsigned i);
    return (n < NUM_NEURONS) ? AW'(n * (NUM_INPUTS + 1) + i) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a,
                                                  input logic relu);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_SHIFT;
    if (relu && s[ACC_W-1]) s = '0;
    else if (s > SAT_MAX)   s = SAT_MAX;
    else if (s < SAT_MIN)   s = SAT_MIN;
    return DATA_W'(s);
  endfunction

  // Lowest pending nonzero input and the working mask with that bit consumed.
  always_comb begin
    sel       = '0;
    wmask_clr = wmask_q;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (wmask_q[i]) sel = XW'(i);
    end
    wmask_clr[sel] = 1'b0;
  end

  always_comb begin
    nbase     = 32'(grp_q) * LANES;
    load_last = (idx_q == XW'(NUM_INPUTS - 1));
    grp_last  = (grp_q == GW'(NUM_GROUPS - 1));
    lane_last = (lane_q == LW'(LANES - 1)) || (nbase + 32'(lane_q) + 1 >= NUM_NEURONS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (in_valid && load_last) state_d = S_BIAS;
      S_BIAS:  state_d = (|mask_q) ? S_MAC : S_EMIT;
      S_MAC:   if (wmask_clr == '0) state_d = S_EMIT;
      S_EMIT:  if (lane_last) state_d = grp_last ? S_DONE : S_BIAS;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    x_d        = x_q;
    mask_d     = mask_q;
    wmask_d    = wmask_q;
    idx_d      = idx_q;
    nnz_d      = nnz_q;
    grp_d      = grp_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    relu_d     = relu_q;
    data_out_d = data_out_q;
    out_idx_d  = out_idx_q;
    for (int k = 0; k < LANES; k++) prod[k] = x_q[sel] * wmem[waddr(nbase + 32'(k), 32'(sel))];
    unique case (state_q)
      S_IDLE: if (start) begin
        relu_d = relu_en;
        mask_d = '0;
        nnz_d  = '0;
        idx_d  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) x_d[i] = '0;
      end
      S_LOAD: if (in_valid) begin
        x_d[idx_q] = in_data;
        if (in_data != '0) begin
          mask_d[idx_q] = 1'b1;
          nnz_d         = nnz_q + NNZ_W'(1);
        end
        idx_d = idx_q + XW'(1);
        if (load_last) begin
          grp_d  = '0;
          lane_d = '0;
        end
      end
      S_BIAS: begin
        wmask_d = mask_q;
        lane_d  = '0;
        for (int k = 0; k < LANES; k++)
          acc_d[k] = ACC_W'(wmem[waddr(nbase + 32'(k), NUM_INPUTS)]);
      end
      S_MAC: begin
        wmask_d = wmask_clr;
        for (int k = 0; k < LANES; k++) acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
      end
      S_EMIT: begin
        if (lane_last) begin
          lane_d = '0;
          if (!grp_last) grp_d = grp_q + GW'(1);
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      default: ;
    endcase
    out_valid_d = (state_d == S_EMIT);
    // Result is registered on the edge that enters each emit cycle, from the final accumulator.
    if (out_valid_d) begin
      data_out_d = scale_sat(acc_d[lane_d], relu_q);
      out_idx_d  = IDX_W'(nbase + 32'(lane_d));
    end
    in_ready_d = (state_d == S_LOAD);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= '0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
      mask_q      <= '0;
      wmask_q     <= '0;
      idx_q       <= '0;
      nnz_q       <= '0;
      grp_q       <= '0;
      lane_q      <= '0;
      relu_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      x_q         <= x_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      wmask_q     <= wmask_d;
      idx_q       <= idx_d;
      nnz_q       <= nnz_d;
      grp_q       <= grp_d;
      lane_q      <= lane_d;
      relu_q      <= relu_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Weight/bias file is not reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (w_we && state_q == S_IDLE && 32'(w_addr) < DEPTH) wmem[w_addr] <= w_data;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign nnz_count = nnz_q;

endmodule

// File: tb/tb_fc_layer_simd.sv
// Directed and randomized bench for fc_layer_simd against an arithmetic reference model
// (partial last group via LANES=3, nonzero output scaling).
module tb_fc_layer_simd;

  localparam int DW    = 8;
  localparam int N     = 10;
  localparam int NI    = 4;
  localparam int L     = 3;
  localparam int ACCW  = 24;
  localparam int FS    = 1;
  localparam int DEPTH = N * (NI + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDXW  = $clog2(N);
  localparam int NNZW  = $clog2(NI + 1);
  localparam int VMAX  = (2 ** (DW - 1)) - 1;
  localparam int VMIN  = -(2 ** (DW - 1));

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            relu_en = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            w_we = 1'b0;
  logic [AW-1:0]   w_addr = '0;
  logic [DW-1:0]   w_data = '0;
  logic            in_ready, out_valid, done, busy;
  logic [DW-1:0]   data_out;
  logic [IDXW-1:0] out_idx;
  logic [NNZW-1:0] nnz_count;

  int compared = 0;
  int mismatched = 0;
  int wt [N][NI+1];
  int xv [NI];

  fc_layer_simd #(
    .DATA_W(DW), .NUM_NEURONS(N), .NUM_INPUTS(NI), .LANES(L), .ACC_W(ACCW), .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .data_out(data_out), .out_idx(out_idx),
    .done(done), .busy(busy), .nnz_count(nnz_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int n, input int i, input int v);
    wt[n][i] = v;
    w_we   = 1'b1;
    w_addr = AW'(n * (NI + 1) + i);
    w_data = DW'(v);
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  // Neuron result straight from the arithmetic definition.
  function automatic int model_out(input int n, input bit relu);
    longint acc;
    acc = wt[n][NI];
    for (int i = 0; i < NI; i++) acc += longint'(xv[i]) * wt[n][i];
    acc = acc >>> FS;
    if (relu && acc < 0) acc = 0;
    if (acc > VMAX) acc = VMAX;
    if (acc < VMIN) acc = VMIN;
    return int'(acc);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  int'(in_ready), 0);
    chk({tag, ".out_valid"}, int'(out_valid), 0);
    chk({tag, ".done"},      int'(done), 0);
    chk({tag, ".busy"},      int'(busy), 0);
    chk({tag, ".data_out"},  int'(data_out), 0);
    chk({tag, ".out_idx"},   int'(out_idx), 0);
    chk({tag, ".nnz"},       int'(nnz_count), 0);
  endtask

  // One inference; abort_at>0 pulls reset at that cycle number instead of finishing.
  task automatic run(input bit relu, input bit disturb, input int abort_at, input string tag);
    int q[$];
    int nnz, ecyc, cyc, li, nout, lastv, expv, lanes;
    bit fin;
    nnz = 0; nout = 0; fin = 1'b0; lastv = 0;
    for (int i = 0; i < NI; i++) if (xv[i] != 0) nnz++;
    for (int n = 0; n < N; n++) q.push_back(model_out(n, relu));
    ecyc = 2 + NI;
    for (int g = 0; g * L < N; g++) begin
      lanes = (N - g * L < L) ? N - g * L : L;
      ecyc += 1 + nnz + lanes;
    end
    start = 1'b1; relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0; relu_en = 1'($urandom_range(0, 1));
    cyc = 2; li = 0;
    while (!fin) begin
      if (li < NI) begin
        chk({tag, ".in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1; in_data = DW'(xv[li]); li++;
      end else begin
        in_valid = 1'($urandom_range(0, 1)); in_data = DW'($urandom);
      end
      if (disturb) begin
        start = 1'b1; w_we = 1'b1;
        w_addr = AW'($urandom_range(0, DEPTH - 1)); w_data = DW'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == abort_at) begin
        rst_n = 1'b0; #1;
        chk_reset_outputs({tag, ".midrst"});
        start = 1'b0; w_we = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".idle_after_rst"}, int'(busy), 0);
        return;
      end
      if (out_valid) begin
        expv = (q.size() > 0) ? q.pop_front() : -999;
        chk({tag, ".idx"},  int'(out_idx), nout);
        chk({tag, ".data"}, int'($signed(data_out)), expv);
        lastv = expv;
        nout++;
      end
      if (done) begin
        chk({tag, ".cycles"}, cyc, ecyc);
        chk({tag, ".count"},  nout, N);
        chk({tag, ".nnz"},    int'(nnz_count), nnz);
        fin = 1'b1;
      end else if (cyc > ecyc + 20) begin
        chk({tag, ".timeout"}, cyc, ecyc);
        fin = 1'b1;
      end
    end
    start = 1'b0; w_we = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, int'(done), 0);
    chk({tag, ".busy_end"},   int'(busy), 0);
    chk({tag, ".hold_data"},  int'($signed(data_out)), lastv);
    chk({tag, ".hold_idx"},   int'(out_idx), N - 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < N; n++) for (int i = 0; i <= NI; i++) wr(n, i, (i == NI) ? 0 : 1);
    xv = '{1, 2, 3, 4};
    run(1'b0, 1'b0, 0, "dense");

    for (int n = 0; n < N; n++)
      for (int i = 0; i <= NI; i++)
        wr(n, i, (i == 1) ? n : (i == NI) ? 0 : $urandom_range(0, 255) - 128);
    xv = '{0, 5, 0, 0};
    run(1'b0, 1'b0, 0, "sparse");

    for (int n = 0; n < N; n++) wr(n, NI, n - 3);
    xv = '{0, 0, 0, 0};
    run(1'b0, 1'b0, 0, "zero");
    run(1'b1, 1'b0, 0, "zero_relu");

    for (int n = 0; n < N; n++) for (int i = 0; i <= NI; i++) wr(n, i, 127);
    xv = '{127, 127, 127, 127};
    run(1'b0, 1'b0, 0, "sat_pos");
    for (int n = 0; n < N; n++) for (int i = 0; i < NI; i++) wr(n, i, -128);
    run(1'b0, 1'b0, 0, "sat_neg");
    run(1'b1, 1'b0, 0, "sat_neg_relu");

    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < N; n++) for (int i = 0; i <= NI; i++) wr(n, i, $urandom_range(0, 255) - 128);
      for (int i = 0; i < NI; i++)
        xv[i] = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(0, 255) - 128;
      run(1'($urandom_range(0, 1)), 1'b0, 0, "rand");
    end

    for (int i = 0; i < NI; i++) xv[i] = $urandom_range(0, 255) - 128;
    run(1'b0, 1'b1, 0, "disturb");

    for (int i = 0; i < NI; i++) xv[i] = $urandom_range(1, 127);
    run(1'b0, 1'b0, NI + 4, "abort");
    run(1'b0, 1'b0, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
